// File: rtl/tune_ctrl_if.sv
// rtl/tune_ctrl_if.sv - signal bundle between host/NCO/demodulator and tune_ctrl
//
// Purpose : groups host configuration, NCO strobe, carrier flag and the
//           tuner outputs so they travel as one port.
// Modports: master - host side (drives cfg_*, sample_stb, carrier_det)
//           slave  - tune_ctrl side (drives phase_inc, gain, pulses)
// Signals : cfg_valid, cfg_phase_inc[25:0], cfg_gain[3:0], cfg_scan_en,
//           sample_stb, carrier_det, phase_inc[25:0], gain[3:0],
//           update_stb, scan_lock, scan_wrap, scanning

interface tune_ctrl_if;
   logic        cfg_valid;
   logic [25:0] cfg_phase_inc;
   logic [3:0]  cfg_gain;
   logic        cfg_scan_en;
   logic        sample_stb;
   logic        carrier_det;
   logic [25:0] phase_inc;
   logic [3:0]  gain;
   logic        update_stb;
   logic        scan_lock;
   logic        scan_wrap;
   logic        scanning;

   modport master (
      output cfg_valid, cfg_phase_inc, cfg_gain, cfg_scan_en,
      output sample_stb, carrier_det,
      input  phase_inc, gain, update_stb, scan_lock, scan_wrap, scanning
   );

   modport slave (
      input  cfg_valid, cfg_phase_inc, cfg_gain, cfg_scan_en,
      input  sample_stb, carrier_det,
      output phase_inc, gain, update_stb, scan_lock, scan_wrap, scanning
   );
endinterface

// File: rtl/tune_ctrl.sv
// rtl/tune_ctrl.sv - NCO tuning controller with fixed tune, channel scan and gain slew
//
// Purpose : holds the NCO phase increment, applies new values only on an NCO
//           sample strobe, steps a scan across channels until a carrier is
//           found, and slews the gain one step per sample toward the target.
// Ports   : CLK - sole clock, rising edge
//           RST - asynchronous active-high reset
//           bus - tune_ctrl_if.slave (host config in, tuner outputs out)

module tune_ctrl #(
   parameter logic [25:0] SCAN_START   = 26'h0F0000,
   parameter logic [25:0] SCAN_STOP    = 26'h1A0000,
   parameter logic [25:0] SCAN_STEP    = 26'h000800,
   parameter logic [23:0] DWELL_CYCLES = 24'd1000000
) (
   input logic         CLK,
   input logic         RST,
   tune_ctrl_if.slave  bus
);

   localparam logic [25:0] RESET_PHASE = 26'h1312EB;
   localparam logic [3:0]  RESET_GAIN  = 4'd7;

   typedef enum logic [1:0] {HOLD, DWELL, STEP} state_t;

   state_t      state_q, state_d;
   logic [25:0] phase_q, phase_d;
   logic [3:0]  gain_q, gain_d;
   logic [3:0]  target_q, target_d;
   logic [25:0] pend_q, pend_d;
   logic        pend_vld_q, pend_vld_d;
   logic [23:0] cnt_q, cnt_d;
   logic        upd_q, upd_d;
   logic        lock_q, lock_d;
   logic        wrap_q, wrap_d;

   // One extra bit so a sum past 2^26 still compares as beyond SCAN_STOP.
   logic [26:0] next_sum;
   logic        next_wraps;

   assign next_sum   = {1'b0, phase_q} + {1'b0, SCAN_STEP};
   assign next_wraps = next_sum > {1'b0, SCAN_STOP};

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= HOLD;
         phase_q    <= RESET_PHASE;
         gain_q     <= RESET_GAIN;
         target_q   <= RESET_GAIN;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         cnt_q      <= '0;
         upd_q      <= 1'b0;
         lock_q     <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         gain_q     <= gain_d;
         target_q   <= target_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         cnt_q      <= cnt_d;
         upd_q      <= upd_d;
         lock_q     <= lock_d;
         wrap_q     <= wrap_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      gain_d     = gain_q;
      target_d   = target_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      cnt_d      = cnt_q;
      upd_d      = 1'b0;
      lock_d     = 1'b0;
      wrap_d     = 1'b0;

      // Gain slews against the target held before this cycle's config.
      if (bus.sample_stb) begin
         if (gain_q < target_q) begin
            gain_d = gain_q + 4'd1;
         end else if (gain_q > target_q) begin
            gain_d = gain_q - 4'd1;
         end
      end

      if (bus.cfg_valid) begin
         // Host config overrides everything; pend_vld_q is still the old
         // value this cycle, so a coincident strobe cannot apply the new one.
         target_d   = bus.cfg_gain;
         pend_vld_d = 1'b1;
         if (bus.cfg_scan_en) begin
            pend_d  = SCAN_START;
            state_d = STEP;
         end else begin
            pend_d  = bus.cfg_phase_inc;
            state_d = HOLD;
         end
      end else if (bus.sample_stb && pend_vld_q) begin
         phase_d    = pend_q;
         pend_vld_d = 1'b0;
         upd_d      = 1'b1;
         if (state_q == STEP) begin
            state_d = DWELL;
            cnt_d   = DWELL_CYCLES - 24'd1;
         end
      end else if (state_q == DWELL) begin
         if (cnt_q != 24'd0) begin
            cnt_d = cnt_q - 24'd1;
         end else if (bus.carrier_det) begin
            state_d = HOLD;
            lock_d  = 1'b1;
         end else begin
            pend_d     = next_wraps ? SCAN_START : next_sum[25:0];
            pend_vld_d = 1'b1;
            wrap_d     = next_wraps;
            state_d    = STEP;
         end
      end
   end

   assign bus.phase_inc  = phase_q;
   assign bus.gain       = gain_q;
   assign bus.update_stb = upd_q;
   assign bus.scan_lock  = lock_q;
   assign bus.scan_wrap  = wrap_q;
   assign bus.scanning   = (state_q != HOLD);

endmodule

// File: tb/tb_tune_ctrl.sv
// tb/tb_tune_ctrl.sv - randomized self-checking bench for tune_ctrl

module tb_tune_ctrl;

   localparam logic [25:0] P_START   = 26'd100;
   localparam logic [25:0] P_STOP    = 26'd120;
   localparam logic [25:0] P_STEP    = 26'd10;
   localparam logic [23:0] P_DWELL   = 24'd4;
   localparam logic [25:0] RST_PHASE = 26'h1312EB;

   logic CLK = 1'b0;
   logic RST;

   tune_ctrl_if bus();

   tune_ctrl #(
      .SCAN_START  (P_START),
      .SCAN_STOP   (P_STOP),
      .SCAN_STEP   (P_STEP),
      .DWELL_CYCLES(P_DWELL)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   logic [25:0] mdl_phase;
   logic [3:0]  mdl_gain;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cfg_valid     = 1'b0;
      bus.cfg_phase_inc = '0;
      bus.cfg_gain      = mdl_gain;
      bus.cfg_scan_en   = 1'b0;
      bus.sample_stb    = 1'b0;
      bus.carrier_det   = 1'b0;
   endtask

   // Scan channel list from the parameter rules: START, +STEP, wrap when past STOP.
   function automatic int scan_val(input int idx);
      int v;
      v = int'(P_START);
      for (int i = 0; i < idx; i++) begin
         v = v + int'(P_STEP);
         if (v > int'(P_STOP)) v = int'(P_START);
      end
      return v;
   endfunction

   task automatic start_scan();
      bus.cfg_valid     = 1'b1;
      bus.cfg_scan_en   = 1'b1;
      bus.cfg_gain      = mdl_gain;
      bus.cfg_phase_inc = 26'($urandom);
      bus.sample_stb    = 1'b0;
      step();
      bus.cfg_valid     = 1'b0;
      bus.cfg_scan_en   = 1'b0;
   endtask

   task automatic test_reset();
      mdl_gain = 4'd7;
      idle_inputs();
      RST = 1'b1;
      repeat (3) step();
      checks++;
      if (bus.phase_inc !== RST_PHASE || bus.gain !== 4'd7) begin
         errors++;
         $display("FAIL reset_hold: phase_inc=%h gain=%0d required phase_inc=%h gain=7", bus.phase_inc, bus.gain, RST_PHASE);
      end
      RST = 1'b0;
      mdl_phase = RST_PHASE;
      for (int c = 0; c < 20; c++) begin
         step();
         checks++;
         if (bus.phase_inc !== RST_PHASE || bus.gain !== 4'd7 ||
             {bus.update_stb, bus.scan_lock, bus.scan_wrap, bus.scanning} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle c%0d: phase_inc=%h gain=%0d pulses=%b required %h 7 0000", c,
                     bus.phase_inc, bus.gain, {bus.update_stb, bus.scan_lock, bus.scan_wrap, bus.scanning}, RST_PHASE);
         end
      end
   endtask

   task automatic test_fixed_tune();
      logic [25:0] val;
      int gap;
      for (int it = 0; it < 4; it++) begin
         val = (it == 0) ? 26'd5000 : 26'($urandom);
         gap = (it == 0) ? 3 : int'($urandom_range(1, 5));
         bus.cfg_valid     = 1'b1;
         bus.cfg_phase_inc = val;
         bus.cfg_gain      = mdl_gain;
         bus.cfg_scan_en   = 1'b0;
         bus.sample_stb    = 1'b1;
         step();
         bus.cfg_valid  = 1'b0;
         bus.sample_stb = 1'b0;
         checks++;
         if (bus.phase_inc !== mdl_phase || bus.update_stb !== 1'b0) begin
            errors++;
            $display("FAIL fx_coincident it%0d: phase_inc=%0d upd=%b required %0d upd=0", it, bus.phase_inc, bus.update_stb, mdl_phase);
         end
         for (int c = 0; c < gap - 1; c++) begin
            step();
            checks++;
            if (bus.phase_inc !== mdl_phase || bus.update_stb !== 1'b0) begin
               errors++;
               $display("FAIL fx_wait it%0d: phase_inc=%0d upd=%b required %0d upd=0", it, bus.phase_inc, bus.update_stb, mdl_phase);
            end
         end
         bus.sample_stb = 1'b1;
         step();
         bus.sample_stb = 1'b0;
         mdl_phase = val;
         checks++;
         if (bus.phase_inc !== val || bus.update_stb !== 1'b1) begin
            errors++;
            $display("FAIL fx_apply it%0d: phase_inc=%0d upd=%b required %0d upd=1", it, bus.phase_inc, bus.update_stb, val);
         end
         step();
         checks++;
         if (bus.phase_inc !== val || bus.update_stb !== 1'b0) begin
            errors++;
            $display("FAIL fx_after it%0d: phase_inc=%0d upd=%b required %0d upd=0", it, bus.phase_inc, bus.update_stb, val);
         end
      end
   endtask

   task automatic test_gain();
      logic [3:0] tgt;
      logic strb;
      for (int it = 0; it < 4; it++) begin
         tgt = (it == 0) ? 4'd3 : 4'($urandom);
         bus.cfg_valid     = 1'b1;
         bus.cfg_gain      = tgt;
         bus.cfg_phase_inc = mdl_phase;
         bus.cfg_scan_en   = 1'b0;
         bus.sample_stb    = 1'b0;
         step();
         bus.cfg_valid = 1'b0;
         for (int c = 0; c < 36; c++) begin
            strb = (it == 0 || c >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.sample_stb = strb;
            step();
            if (strb) begin
               if (mdl_gain < tgt) mdl_gain = mdl_gain + 4'd1;
               else if (mdl_gain > tgt) mdl_gain = mdl_gain - 4'd1;
            end
            checks++;
            if (bus.gain !== mdl_gain || bus.phase_inc !== mdl_phase) begin
               errors++;
               $display("FAIL gain it%0d c%0d: gain=%0d phase_inc=%0d required gain=%0d phase_inc=%0d", it, c, bus.gain, bus.phase_inc, mdl_gain, mdl_phase);
            end
         end
         bus.sample_stb = 1'b0;
      end
   endtask

   task automatic test_scan(input bit rand_stb);
      int vals[$];
      int at[$];
      int wrap_pos[$];
      int first_wrap_exp;
      int drops;
      logic [25:0] val;
      bus.carrier_det = 1'b0;
      start_scan();
      drops = 0;
      for (int c = 0; c < 400 && vals.size() < 6; c++) begin
         bus.sample_stb = rand_stb ? 1'($urandom_range(0, 1)) : 1'b1;
         step();
         if (bus.scanning !== 1'b1) drops++;
         if (bus.scan_wrap === 1'b1) wrap_pos.push_back(vals.size());
         if (bus.update_stb === 1'b1) begin
            vals.push_back(int'(bus.phase_inc));
            at.push_back(c);
         end
      end
      bus.sample_stb = 1'b0;
      checks++;
      if (vals.size() != 6) begin
         errors++;
         $display("FAIL scan_count rs%0d: updates=%0d required 6", rand_stb, vals.size());
      end
      checks++;
      if (drops != 0) begin
         errors++;
         $display("FAIL scan_active rs%0d: cycles with scanning low=%0d required 0", rand_stb, drops);
      end
      for (int i = 0; i < vals.size(); i++) begin
         checks++;
         if (vals[i] != scan_val(i)) begin
            errors++;
            $display("FAIL scan_value rs%0d #%0d: phase_inc=%0d required %0d", rand_stb, i, vals[i], scan_val(i));
         end
         if (!rand_stb && i > 0) begin
            checks++;
            if (at[i] - at[i-1] != int'(P_DWELL) + 1) begin
               errors++;
               $display("FAIL scan_dwell #%0d: spacing=%0d required %0d", i, at[i] - at[i-1], int'(P_DWELL) + 1);
            end
         end
      end
      first_wrap_exp = -1;
      for (int i = 5; i >= 1; i--) if (scan_val(i) == int'(P_START)) first_wrap_exp = i;
      checks++;
      if (wrap_pos.size() != 1 || wrap_pos[0] != first_wrap_exp) begin
         errors++;
         $display("FAIL scan_wrap rs%0d: wraps=%0d first_after_update=%0d required 1 wrap after update %0d", rand_stb,
                  wrap_pos.size(), (wrap_pos.size() > 0) ? wrap_pos[0] : -1, first_wrap_exp);
      end
      // A fixed-tune config must override the running scan.
      val = 26'($urandom);
      bus.cfg_valid     = 1'b1;
      bus.cfg_phase_inc = val;
      bus.cfg_gain      = mdl_gain;
      bus.cfg_scan_en   = 1'b0;
      step();
      bus.cfg_valid = 1'b0;
      checks++;
      if (bus.scanning !== 1'b0) begin
         errors++;
         $display("FAIL scan_override rs%0d: scanning=%b required 0", rand_stb, bus.scanning);
      end
      bus.sample_stb = 1'b1;
      step();
      bus.sample_stb = 1'b0;
      mdl_phase = val;
      checks++;
      if (bus.phase_inc !== val || bus.update_stb !== 1'b1) begin
         errors++;
         $display("FAIL scan_override_apply rs%0d: phase_inc=%0d upd=%b required %0d upd=1", rand_stb, bus.phase_inc, bus.update_stb, val);
      end
   endtask

   task automatic test_lock();
      int k, seen, locks, lock_at, late_upd;
      bit found;
      for (int it = 0; it < 3; it++) begin
         k = (it == 0) ? 1 : int'($urandom_range(0, 3));
         bus.carrier_det = 1'b0;
         start_scan();
         seen = 0;
         found = 0;
         for (int c = 0; c < 200 && !found; c++) begin
            bus.sample_stb = 1'b1;
            step();
            if (bus.update_stb === 1'b1) begin
               if (seen == k) found = 1;
               seen++;
            end
         end
         checks++;
         if (!found) begin
            errors++;
            $display("FAIL lock_reach it%0d: updates seen=%0d required %0d", it, seen, k + 1);
         end
         bus.carrier_det = 1'b1;
         locks = 0;
         lock_at = -1;
         late_upd = 0;
         for (int c = 1; c <= 20; c++) begin
            step();
            if (bus.scan_lock === 1'b1) begin
               locks++;
               lock_at = c;
            end
            if (bus.update_stb === 1'b1) late_upd++;
         end
         bus.sample_stb  = 1'b0;
         bus.carrier_det = 1'b0;
         mdl_phase = 26'(scan_val(k));
         checks++;
         if (locks != 1 || lock_at != int'(P_DWELL)) begin
            errors++;
            $display("FAIL lock_pulse it%0d: pulses=%0d at=%0d required 1 at %0d", it, locks, lock_at, int'(P_DWELL));
         end
         checks++;
         if (bus.scanning !== 1'b0 || bus.phase_inc !== mdl_phase || late_upd != 0) begin
            errors++;
            $display("FAIL lock_hold it%0d: scanning=%b phase_inc=%0d updates=%0d required 0 %0d 0", it, bus.scanning, bus.phase_inc, late_upd, mdl_phase);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [25:0] v1, v2;
      int upd;
      v1 = 26'($urandom);
      v2 = 26'($urandom);
      bus.cfg_valid     = 1'b1;
      bus.cfg_scan_en   = 1'b0;
      bus.cfg_gain      = mdl_gain;
      bus.cfg_phase_inc = v1;
      step();
      bus.cfg_phase_inc = v2;
      step();
      bus.cfg_valid = 1'b0;
      bus.sample_stb = 1'b1;
      step();
      mdl_phase = v2;
      checks++;
      if (bus.phase_inc !== v2 || bus.update_stb !== 1'b1) begin
         errors++;
         $display("FAIL b2b_apply: phase_inc=%0d upd=%b required %0d upd=1", bus.phase_inc, bus.update_stb, v2);
      end
      upd = 0;
      for (int c = 0; c < 12; c++) begin
         bus.sample_stb  = 1'($urandom_range(0, 1));
         bus.carrier_det = 1'($urandom_range(0, 1));
         step();
         if (bus.update_stb === 1'b1 || bus.phase_inc !== mdl_phase || bus.scanning !== 1'b0) upd++;
      end
      bus.sample_stb  = 1'b0;
      bus.carrier_det = 1'b0;
      checks++;
      if (upd != 0) begin
         errors++;
         $display("FAIL hold_idle: cycles with change=%0d required 0", upd);
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      for (int cs = 0; cs < 2; cs++) begin
         bus.carrier_det = 1'b0;
         mdl_gain = 4'($urandom);
         start_scan();
         bus.sample_stb = (cs == 0);
         step();
         step();
         step();
         #3;
         RST = 1'b1;
         #1;
         checks++;
         if (bus.phase_inc !== RST_PHASE || bus.gain !== 4'd7 ||
             {bus.update_stb, bus.scan_lock, bus.scan_wrap, bus.scanning} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_async cs%0d: phase_inc=%h gain=%0d pulses=%b required %h 7 0000", cs,
                     bus.phase_inc, bus.gain, {bus.update_stb, bus.scan_lock, bus.scan_wrap, bus.scanning}, RST_PHASE);
         end
         step();
         RST = 1'b0;
         mdl_gain  = 4'd7;
         mdl_phase = RST_PHASE;
         bad = 0;
         for (int c = 0; c < 15; c++) begin
            bus.sample_stb  = 1'b1;
            bus.carrier_det = 1'($urandom_range(0, 1));
            step();
            if (bus.update_stb !== 1'b0 || bus.phase_inc !== RST_PHASE ||
                bus.scanning !== 1'b0 || bus.gain !== 4'd7) bad++;
         end
         bus.sample_stb  = 1'b0;
         bus.carrier_det = 1'b0;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL rst_release cs%0d: cycles off reset state=%0d required 0", cs, bad);
         end
      end
   endtask

   initial begin
      mdl_gain = 4'd7;
      mdl_phase = RST_PHASE;
      RST = 1'b1;
      idle_inputs();
      test_reset();
      test_fixed_tune();
      test_gain();
      test_scan(1'b0);
      test_scan(1'b1);
      test_lock();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tune_ctrl.md
TUNE_CTRL -- requirements
Module: tune_ctrl

Interface
REQ-001 SHALL have parameter SCAN_START, default 26'h0F0000, first phase increment of a scan.
REQ-002 SHALL have parameter SCAN_STOP, default 26'h1A0000, last legal scan phase increment, inclusive.
REQ-003 SHALL have parameter SCAN_STEP, default 26'h000800, phase increment added per scan step.
REQ-004 SHALL have parameter DWELL_CYCLES, default 24'd1000000, CLK cycles per scan channel; legal range 1 to 2^24-1.
REQ-005 SHALL have port CLK  input  1  sole clock, all logic on rising edge; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port RST  input  1  asynchronous active-high reset.
REQ-007 SHALL have port cfg_valid  input  1  one-cycle pulse, new host configuration present.
REQ-008 SHALL have port cfg_phase_inc  input  26  host phase increment, sampled when cfg_valid=1.
REQ-009 SHALL have port cfg_gain  input  4  host target gain, sampled when cfg_valid=1.
REQ-010 SHALL have port cfg_scan_en  input  1  1 = start scan, 0 = fixed tune; sampled when cfg_valid=1.
REQ-011 SHALL have port sample_stb  input  1  NCO sample strobe, one-cycle pulse.
REQ-012 SHALL have port carrier_det  input  1  carrier-present flag from demodulator, level.
REQ-013 SHALL have port phase_inc  output  26  registered NCO phase increment.
REQ-014 SHALL have port gain  output  4  registered, slew-limited gain.
REQ-015 SHALL have port update_stb  output  1  one-cycle pulse, high in the cycle phase_inc shows a newly applied value.
REQ-016 SHALL have port scan_lock  output  1  one-cycle pulse, scan stopped on carrier.
REQ-017 SHALL have port scan_wrap  output  1  one-cycle pulse, scan wrapped STOP to START.
REQ-018 SHALL have port scanning  output  1  high in DWELL and STEP states.

Function
REQ-019 SHALL implement states HOLD, DWELL, STEP.
REQ-020 SHALL hold a pending register (26-bit value plus valid flag); phase_inc SHALL change only in the cycle after a sample_stb on which pending is valid, then clear pending and pulse update_stb with the new value.
REQ-021 SHALL apply pending only on a sample_stb strictly after the cycle pending was written; a strobe coincident with the write SHALL NOT apply it.
REQ-022 SHALL, on cfg_valid with cfg_scan_en=0 in any state: pending <= cfg_phase_inc, gain target <= cfg_gain, state <= HOLD.
REQ-023 SHALL, on cfg_valid with cfg_scan_en=1 in any state: pending <= SCAN_START, gain target <= cfg_gain, state <= STEP; cfg_phase_inc ignored.
REQ-024 SHALL give cfg_valid priority over every internal transition in the same cycle.
REQ-025 SHALL, in STEP, apply pending per REQ-020 and on that application enter DWELL with dwell counter <= DWELL_CYCLES-1.
REQ-026 SHALL, in DWELL, decrement the counter each CLK; at counter 0 with carrier_det=1: state <= HOLD, pulse scan_lock, phase_inc unchanged.
REQ-027 SHALL, in DWELL at counter 0 with carrier_det=0: pending <= next value, state <= STEP.
REQ-028 SHALL compute next value in 27 bits: phase_inc + SCAN_STEP; if result > SCAN_STOP, next value = SCAN_START and scan_wrap pulses in the same cycle pending is written.
REQ-029 SHALL, on each sample_stb, move gain one step toward target (+1 if below, -1 if above, unchanged if equal); no overflow or underflow possible.
REQ-030 SHALL NOT modify gain target from scan logic.
REQ-031 SHALL, in HOLD with no pending, keep phase_inc and state constant regardless of sample_stb or carrier_det.

Reset
REQ-032 SHALL, while RST=1, immediately force phase_inc=26'h1312EB, gain=4'd7, gain target=4'd7, state=HOLD, pending cleared, dwell counter=0, update_stb=scan_lock=scan_wrap=scanning=0.
REQ-033 SHALL discard any pending update and abort any scan on reset mid-operation; first edge after RST release SHALL behave as HOLD with no pending.

Verification (bench parameters SCAN_START=100, SCAN_STOP=120, SCAN_STEP=10, DWELL_CYCLES=4)
REQ-034 SHALL cover: reset released, no stimulus -> phase_inc=26'h1312EB, gain=7, all pulses 0 indefinitely.
REQ-035 SHALL cover: cfg_valid phase 5000, scan_en=0, sample_stb in same cycle then 3 cycles later -> no change on first strobe; phase_inc=5000 plus one update_stb after second.
REQ-036 SHALL cover: scan start, carrier_det=0, sample_stb every cycle -> phase_inc 100,110,120,100, each held 4 cycles DWELL; scan_wrap once before 100 reapplied.
REQ-037 SHALL cover: scan running, carrier_det=1 at end of 110 dwell -> scan_lock single pulse, scanning=0, phase_inc stays 110.
REQ-038 SHALL cover: gain 7, cfg_gain=3 -> gain 6,5,4,3 on four successive sample_stb, then constant.
REQ-039 SHALL cover: RST asserted mid-DWELL with pending valid -> outputs reset values same cycle; no update_stb after release.
